sum_group_accumulator: RTL and testbench

//  Downstream stage of the valid/ready adder: consumes its sum stream, adds

---
 rtl/sum_group_accumulator.sv | 63 ++++++
 tb/tb_sum_group_accumulator.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sum_group_accumulator.sv
// Adds COUNT consecutive sums from the adder stream and emits one registered
// group total per COUNT inputs, with valid/ready handshakes on both sides.
module sum_group_accumulator #(
    parameter  int WIDTH = 5,
    parameter  int COUNT = 4,
    localparam int OUT_W = WIDTH + $clog2(COUNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [OUT_W-1:0] out_data,
    output logic [7:0]       grp_cnt
);

    localparam logic [7:0] LAST_IDX = 8'(COUNT - 1);

    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] sum;
    logic             last;
    logic             in_hs;
    logic             out_hs;

    // Only the closing sample can stall, and only while the previous total
    // is still sitting in the output register without being drained.
    assign last   = (grp_cnt == LAST_IDX);
    assign in_rdy = !last || !out_vld || out_rdy;
    assign in_hs  = in_vld && in_rdy;
    assign out_hs = out_vld && out_rdy;
    assign sum    = acc + OUT_W'(in_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            grp_cnt <= '0;
        end else if (in_hs) begin
            if (last) begin
                acc     <= '0;
                grp_cnt <= '0;
            end else begin
                acc     <= sum;
                grp_cnt <= grp_cnt + 8'd1;
            end
        end
    end

    // A closing load wins over a drain so back-to-back totals leave no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (in_hs && last) begin
            out_vld  <= 1'b1;
            out_data <= sum;
        end else if (out_hs) begin
            out_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sum_group_accumulator.sv
// Directed and randomised bench for sum_group_accumulator (WIDTH=5, COUNT=4)
// with a queue-based model checked every cycle plus literal expectations.
module tb_sum_group_accumulator;

    localparam int WIDTH = 5;
    localparam int COUNT = 4;
    localparam int OUT_W = WIDTH + $clog2(COUNT);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] in_data;
    logic             out_vld;
    logic             out_rdy;
    logic [OUT_W-1:0] out_data;
    logic [7:0]       grp_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;
    int n_out = 0;
    int exp_q[$];
    int part_q[$];
    bit exp_in_rdy;

    sum_group_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .grp_cnt  (grp_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r);
        in_vld  = v;
        in_data = d;
        out_rdy = r;
        @(posedge clk);
        #1;
    endtask

    // Model: partial group and pending totals as queues; advanced at each
    // negedge to represent what the following posedge will capture.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            part_q.delete();
        end else begin
            exp_in_rdy = !(part_q.size() == COUNT - 1 && exp_q.size() > 0 && !out_rdy);
            checkOutput("in_rdy", in_rdy, int'(exp_in_rdy));
            checkOutput("out_vld", out_vld, int'(exp_q.size() > 0));
            if (exp_q.size() > 0)
                checkOutput("out_data", out_data, exp_q[0]);
            checkOutput("grp_cnt", grp_cnt, part_q.size());
            if (out_vld && out_rdy)
                n_out++;
            if (exp_q.size() > 0 && out_rdy)
                void'(exp_q.pop_front());
            if (in_vld && exp_in_rdy) begin
                n_acc++;
                part_q.push_back(int'(in_data));
                if (part_q.size() == COUNT) begin
                    int total;
                    total = 0;
                    foreach (part_q[i]) total += part_q[i];
                    exp_q.push_back(total);
                    part_q.delete();
                end
            end
        end
    end

    initial begin
        int n_out0;
        int n_acc0;
        int cyc;

        in_vld  = 1'b0;
        in_data = '0;
        out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("rst_in_rdy", in_rdy, 1);
        checkOutput("rst_out_vld", out_vld, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_grp_cnt", grp_cnt, 0);

        // Reset asserted mid-group with a total pending
        applyStimulus(1, 1, 0);
        applyStimulus(1, 2, 0);
        applyStimulus(1, 3, 0);
        applyStimulus(1, 4, 0);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 2, 0);
        in_vld = 1'b0;
        checkOutput("pre_rst_out_vld", out_vld, 1);
        checkOutput("pre_rst_grp_cnt", grp_cnt, 2);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_out_vld", out_vld, 0);
        checkOutput("async_rst_grp_cnt", grp_cnt, 0);
        checkOutput("async_rst_out_data", out_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic group 1+2+3+4
        applyStimulus(1, 1, 1);
        applyStimulus(1, 2, 1);
        applyStimulus(1, 3, 1);
        checkOutput("basic_grp_cnt3", grp_cnt, 3);
        checkOutput("basic_not_yet", out_vld, 0);
        applyStimulus(1, 4, 1);
        in_vld = 1'b0;
        checkOutput("basic_out_vld", out_vld, 1);
        checkOutput("basic_out_data", out_data, 10);
        checkOutput("basic_grp_wrap", grp_cnt, 0);
        applyStimulus(0, 0, 1);
        checkOutput("basic_one_cycle", out_vld, 0);

        // Maximum inputs
        repeat (4) applyStimulus(1, 31, 1);
        in_vld = 1'b0;
        checkOutput("max_out_data", out_data, 124);
        checkOutput("max_out_vld", out_vld, 1);
        applyStimulus(0, 0, 1);

        // Backpressure on the closing sample
        applyStimulus(1, 1, 0);
        applyStimulus(1, 2, 0);
        applyStimulus(1, 3, 0);
        applyStimulus(1, 4, 0);
        repeat (3) applyStimulus(1, 5, 0);
        checkOutput("bp_grp_cnt", grp_cnt, 3);
        in_vld  = 1'b1;
        in_data = 5;
        out_rdy = 1'b0;
        #1;
        checkOutput("bp_in_rdy_low", in_rdy, 0);
        @(posedge clk);
        #1;
        checkOutput("bp_held_data", out_data, 10);
        checkOutput("bp_held_vld", out_vld, 1);
        checkOutput("bp_held_grp", grp_cnt, 3);
        out_rdy = 1'b1;
        #1;
        checkOutput("bp_in_rdy_high", in_rdy, 1);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        checkOutput("bp_new_data", out_data, 20);
        checkOutput("bp_new_vld", out_vld, 1);
        checkOutput("bp_new_grp", grp_cnt, 0);
        applyStimulus(0, 0, 1);
        checkOutput("bp_drained", out_vld, 0);

        // Streaming, no bubbles
        n_out0 = n_out;
        for (int i = 0; i < 8; i++) begin
            in_vld  = 1'b1;
            in_data = 1;
            out_rdy = 1'b1;
            #1;
            checkOutput("stream_in_rdy", in_rdy, 1);
            @(posedge clk);
            #1;
            if (i == 3 || i == 7) begin
                checkOutput("stream_out_vld", out_vld, 1);
                checkOutput("stream_out_data", out_data, 4);
            end
        end
        applyStimulus(0, 0, 1);
        checkOutput("stream_totals", n_out - n_out0, 2);

        // Random valid/ready over 1000 samples
        n_out0 = n_out;
        n_acc0 = n_acc;
        cyc = 0;
        while (n_acc - n_acc0 < 1000 && cyc < 20000) begin
            in_vld  = ($urandom_range(0, 3) != 0);
            in_data = WIDTH'($urandom_range(0, 31));
            out_rdy = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        in_vld = 1'b0;
        checkOutput("rand_accepted", n_acc - n_acc0, 1000);
        out_rdy = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("rand_totals", n_out - n_out0, 250);
        checkOutput("rand_end_vld", out_vld, 0);
        checkOutput("rand_end_grp", grp_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
